// File: rtl/ula_seq.sv
// Registered ALU: single-cycle ADD/SUB/CMP/SIP/AND/OR/XOR, shift-add MUL over WIDTH cycles.
// State | meaning: S_IDLE | accept start, single-cycle ops complete here; S_MUL | shift-add in progress
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       UlaOp,
  input  logic [WIDTH-1:0] Dado1,
  input  logic [WIDTH-1:0] Dado2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Resultado,
  output logic             Zero,
  output logic             Carry
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_SIP = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               r_state, w_state;
  logic [WIDTH-1:0]     r_res, w_res;
  logic                 r_zero, w_zero;
  logic                 r_carry, w_carry;
  logic                 r_done, w_done;
  logic [2*WIDTH-1:0]   r_mcand, w_mcand;
  logic [WIDTH-1:0]     r_mplier, w_mplier;
  logic [2*WIDTH-1:0]   r_acc, w_acc;
  logic [CW-1:0]        r_cnt, w_cnt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_alu_res;
  logic                 w_alu_carry;
  logic [2*WIDTH-1:0]   w_acc_step;

  assign w_sum      = {1'b0, Dado1} + {1'b0, Dado2};
  assign w_diff     = {1'b0, Dado1} - {1'b0, Dado2};
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_alu_res   = r_res;
    w_alu_carry = 1'b0;
    case (UlaOp)
      OP_ADD:  begin w_alu_res = w_sum[WIDTH-1:0];  w_alu_carry = w_sum[WIDTH];  end
      OP_SUB:  begin w_alu_res = w_diff[WIDTH-1:0]; w_alu_carry = w_diff[WIDTH]; end
      OP_SIP:  w_alu_res = Dado1[0] ? '0 : '1;
      OP_AND:  w_alu_res = Dado1 & Dado2;
      OP_OR:   w_alu_res = Dado1 | Dado2;
      OP_XOR:  w_alu_res = Dado1 ^ Dado2;
      default: w_alu_res = r_res;
    endcase
  end

  always_comb begin
    w_state  = r_state;
    w_res    = r_res;
    w_zero   = r_zero;
    w_carry  = r_carry;
    w_done   = 1'b0;
    w_mcand  = r_mcand;
    w_mplier = r_mplier;
    w_acc    = r_acc;
    w_cnt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (UlaOp == OP_MUL) begin
            w_mcand  = {{WIDTH{1'b0}}, Dado1};
            w_mplier = Dado2;
            w_acc    = '0;
            w_cnt    = CW'(WIDTH);
            w_state  = S_MUL;
          end else begin
            // CMP only touches the flags; Resultado keeps the previous value
            if (UlaOp == OP_CMP) begin
              w_zero  = (Dado1 == Dado2);
              w_carry = w_diff[WIDTH];
            end else begin
              w_res   = w_alu_res;
              w_zero  = (w_alu_res == '0);
              w_carry = w_alu_carry;
            end
            w_done = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_acc    = w_acc_step;
        w_mcand  = r_mcand << 1;
        w_mplier = r_mplier >> 1;
        w_cnt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_res   = w_acc_step[WIDTH-1:0];
          w_zero  = (w_acc_step[WIDTH-1:0] == '0);
          w_carry = |w_acc_step[2*WIDTH-1:WIDTH];
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_res    <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_res    <= w_res;
      r_zero   <= w_zero;
      r_carry  <= w_carry;
      r_done   <= w_done;
      r_mcand  <= w_mcand;
      r_mplier <= w_mplier;
      r_acc    <= w_acc;
      r_cnt    <= w_cnt;
    end
  end

  assign busy      = (r_state == S_MUL);
  assign done      = r_done;
  assign Resultado = r_res;
  assign Zero      = r_zero;
  assign Carry     = r_carry;

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq at WIDTH = 8: expected results are queued at issue and popped on done.
module tb_ula_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   UlaOp = 3'b000;
  logic [W-1:0] Dado1 = '0;
  logic [W-1:0] Dado2 = '0;
  logic         busy, done, Zero, Carry;
  logic [W-1:0] Resultado;

  ula_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .UlaOp(UlaOp),
    .Dado1(Dado1), .Dado2(Dado2), .busy(busy), .done(done),
    .Resultado(Resultado), .Zero(Zero), .Carry(Carry)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] m_res = '0;

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] prev);
    exp_t e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    e.res   = prev;
    e.carry = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.carry = s[W]; end
      3'd1: begin e.res = a - b; e.carry = (a < b); end
      3'd2: e.carry = (a < b);
      3'd3: e.res = a[0] ? '0 : '1;
      3'd4: e.res = a & b;
      3'd5: e.res = a | b;
      3'd6: e.res = a ^ b;
      default: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0];
        e.carry = |p[2*W-1:W];
      end
    endcase
    e.zero = (op == 3'd2) ? (a == b) : (e.res == '0);
    return e;
  endfunction

  // Drives one start pulse; returns at the falling edge right after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    exp_t e;
    @(negedge clk);
    UlaOp = op; Dado1 = a; Dado2 = b; start = 1'b1;
    if (push) begin
      e = model(op, a, b, m_res);
      exp_q.push_back(e);
      m_res = e.res;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if ({Resultado, Zero, Carry} !== '0) begin n_err++;
      $display("FAIL reset_outputs got %h/%b/%b want 00/0/0", Resultado, Zero, Carry); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [2:0]   ops [11] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd6, 3'd5, 3'd2};
    logic [W-1:0] as  [11] = '{8'hC8, 8'h80, 8'h05, 8'h03, 8'h5A, 8'h04, 8'h05, 8'hF0, 8'hA5, 8'h0F, 8'h10};
    logic [W-1:0] bs  [11] = '{8'h64, 8'h80, 8'h05, 8'h05, 8'h5A, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hF0, 8'h20};
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1);
      e = exp_q.pop_front();
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL single_done[%0d] got %b want 1", i, done); end
      n_vec++; if (Resultado !== e.res) begin n_err++;
        $display("FAIL single_res[%0d] op %0d got %h want %h", i, ops[i], Resultado, e.res); end
      n_vec++; if (Zero !== e.zero) begin n_err++;
        $display("FAIL single_zero[%0d] op %0d got %b want %b", i, ops[i], Zero, e.zero); end
      n_vec++; if (Carry !== e.carry) begin n_err++;
        $display("FAIL single_carry[%0d] op %0d got %b want %b", i, ops[i], Carry, e.carry); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_drop[%0d] got %b want 0", i, done); end
    end
    // CMP must leave Resultado from the preceding SUB (0xFE) untouched
    issue(3'd1, 8'h03, 8'h05, 1'b1);
    void'(exp_q.pop_front());
    issue(3'd2, 8'h5A, 8'h5A, 1'b1);
    e = exp_q.pop_front();
    n_vec++; if ({Resultado, Zero, Carry} !== {8'hFE, 1'b1, 1'b0}) begin n_err++;
      $display("FAIL cmp_hold got %h/%b/%b want fe/1/0", Resultado, Zero, Carry); end
    n_vec++; if ({Resultado, Zero, Carry} !== e) begin n_err++;
      $display("FAIL cmp_hold_sb got %h/%b/%b want %h/%b/%b", Resultado, Zero, Carry, e.res, e.zero, e.carry); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   op;
    logic [W-1:0] a, b;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done[%0d] got %b want 1", i, done); end
        n_vec++; if ({Resultado, Zero, Carry} !== e) begin n_err++;
          $display("FAIL b2b_out[%0d] got %h/%b/%b want %h/%b/%b", i, Resultado, Zero, Carry, e.res, e.zero, e.carry); end
      end
      if (i < 8) begin
        op = 3'($urandom_range(0, 6));
        a = 8'($urandom_range(0, 255));
        b = (i == 3) ? a : 8'($urandom_range(0, 255));
        UlaOp = op; Dado1 = a; Dado2 = b; start = 1'b1;
        e = model(op, a, b, m_res);
        exp_q.push_back(e);
        m_res = e.res;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_drop got %b want 0", done); end
  endtask

  task automatic test_mul();
    logic [W-1:0] as [4] = '{8'h0D, 8'h14, 8'hFF, 8'h00};
    logic [W-1:0] bs [4] = '{8'h0B, 8'h14, 8'hFF, 8'h37};
    int cnt;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(3'd7, as[i], bs[i], 1'b1);
      cnt = 0;
      while (busy === 1'b1 && cnt < 20) begin
        if (done !== 1'b0) begin n_err++; n_vec++; $display("FAIL mul_done_busy[%0d] got done %b while busy", i, done); end
        cnt++;
        @(negedge clk);
      end
      e = exp_q.pop_front();
      n_vec++; if (cnt != W) begin n_err++; $display("FAIL mul_busy_len[%0d] got %0d want %0d", i, cnt, W); end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL mul_done[%0d] got %b want 1", i, done); end
      n_vec++; if ({Resultado, Zero, Carry} !== e) begin n_err++;
        $display("FAIL mul_out[%0d] got %h/%b/%b want %h/%b/%b", i, Resultado, Zero, Carry, e.res, e.zero, e.carry); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mul_done_drop[%0d] got %b want 0", i, done); end
    end
  endtask

  task automatic test_handshake();
    int n_done;
    logic [W-1:0] r_seen;
    exp_t e;
    issue(3'd7, 8'h0D, 8'h0B, 1'b1);
    @(negedge clk);
    UlaOp = 3'd0; Dado1 = 8'h77; Dado2 = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0; Dado1 = 8'h33; Dado2 = 8'h99;
    n_done = 0;
    r_seen = '0;
    for (int i = 0; i < 16; i++) begin
      if (done === 1'b1) begin n_done++; r_seen = Resultado; end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    n_vec++; if (n_done != 1) begin n_err++; $display("FAIL hs_done_count got %0d want 1", n_done); end
    n_vec++; if (r_seen !== e.res) begin n_err++; $display("FAIL hs_result got %h want %h", r_seen, e.res); end
    n_vec++; if (Carry !== e.carry) begin n_err++; $display("FAIL hs_carry got %b want %b", Carry, e.carry); end
  endtask

  task automatic test_reset_mid_mul();
    int n_done;
    exp_t e;
    issue(3'd7, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    start = 1'b1; UlaOp = 3'd0; Dado1 = 8'h10; Dado2 = 8'h20;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_vec++; if ({Resultado, Zero, Carry, done} !== '0) begin n_err++;
      $display("FAIL rst_mid_outputs got %h/%b/%b/%b want 00/0/0/0", Resultado, Zero, Carry, done); end
    m_res = '0;
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) n_done++;
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) n_done++;
    end
    n_vec++; if (n_done != 0) begin n_err++; $display("FAIL rst_mid_activity got %0d cycles want 0", n_done); end
    issue(3'd0, 8'h01, 8'h01, 1'b1);
    e = exp_q.pop_front();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL post_rst_done got %b want 1", done); end
    n_vec++; if ({Resultado, Zero, Carry} !== {8'h02, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL post_rst_add got %h/%b/%b want 02/0/0", Resultado, Zero, Carry); end
    n_vec++; if (Resultado !== e.res) begin n_err++; $display("FAIL post_rst_sb got %h want %h", Resultado, e.res); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mul();
    test_handshake();
    test_reset_mid_mul();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
